// File: rtl/note_sequencer.sv
// note_sequencer: timed note FIFO replaying {channel, divider} writes to the square-wave sound block.
// Build option: define NOTE_SEQ_AUTO_MUTE_EN to end every timed note with a divider-0 write.
module note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic        addr,
    input  logic [15:0] data_in,
    output logic        snd_wr_en,
    output logic [15:0] snd_data,
    output logic [3:0]  status
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);

    // state  | meaning
    // IDLE   | waiting for a queued note
    // ISSUE  | one-cycle note write to the sound block
    // WAIT   | counting the note duration in ticks
    // MUTE   | one-cycle divider-0 write closing the note (auto-mute builds only)
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
`ifdef NOTE_SEQ_AUTO_MUTE_EN
        ,
        S_MUTE
`endif
    } state_t;

`ifdef NOTE_SEQ_AUTO_MUTE_EN
    localparam state_t S_END = S_MUTE;
`else
    localparam state_t S_END = S_IDLE;
`endif

    state_t        r_state;
    logic [15:0]   r_cur_note;
    logic [11:0]   r_cur_dur;
    logic [11:0]   r_remaining;
    logic [PW-1:0] r_presc;
    logic          r_snd_wr_en;
    logic [15:0]   r_snd_data;
    logic [11:0]   r_dur_reg;
    logic          r_overflow;

    logic [27:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_note_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [27:0] w_head;

    assign w_wr      = en && wr_en;
    assign w_ctrl_wr = w_wr && addr;
    assign w_flush   = w_ctrl_wr && data_in[15];
    assign w_note_wr = w_wr && !addr;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A full FIFO rejects the push even when a pop frees a slot on the same edge.
    assign w_push    = w_note_wr && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty && !w_flush;
    assign w_head    = r_mem[r_rd_ptr];

    assign snd_wr_en = r_snd_wr_en;
    assign snd_data  = r_snd_data;
    assign status    = {r_state != S_IDLE, w_full, w_empty, r_overflow};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {data_in, r_dur_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dur_reg  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_dur_reg <= data_in[11:0];
                if (data_in[14]) begin
                    r_overflow <= 1'b0;
                end
            end
            if (w_note_wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_note  <= '0;
            r_cur_dur   <= '0;
            r_remaining <= '0;
            r_presc     <= '0;
            r_snd_wr_en <= 1'b0;
            r_snd_data  <= '0;
        end else begin
            r_snd_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur_note <= w_head[27:12];
                        r_cur_dur  <= w_head[11:0];
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_snd_wr_en <= 1'b1;
                    r_snd_data  <= r_cur_note;
                    r_presc     <= PRESC_LOAD;
                    r_remaining <= r_cur_dur;
                    if (r_cur_dur == '0) begin
                        r_state <= S_IDLE;
                    end else if (w_flush) begin
                        r_state <= S_END;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_flush) begin
                        r_state <= S_END;
                    end else if (r_presc == '0) begin
                        r_presc     <= PRESC_LOAD;
                        r_remaining <= r_remaining - 12'd1;
                        if (r_remaining == 12'd1) begin
                            r_state <= S_END;
                        end
                    end else begin
                        r_presc <= r_presc - PW'(1);
                    end
                end
`ifdef NOTE_SEQ_AUTO_MUTE_EN
                S_MUTE: begin
                    r_snd_wr_en <= 1'b1;
                    r_snd_data  <= {r_cur_note[15:14], 14'b0};
                    r_state     <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus random bus traffic checked every cycle
// against a queue-based model that predicts write pulses from the note timing rules.
module tb_note_sequencer;
    localparam int DEPTH = 4;
    localparam int TD    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic        addr;
    logic [15:0] data_in;
    logic        snd_wr_en;
    logic [15:0] snd_data;
    logic [3:0]  status;

    note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_in  (data_in),
        .snd_wr_en(snd_wr_en),
        .snd_data (snd_data),
        .status   (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } pulse_t;

    pulse_t      exp_q[$];
    pulse_t      log_q[$];
    logic [27:0] mq[$];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_idle_from = 0;
    int          m_t = 0;
    int          m_end = 0;
    int          m_d = 0;
    logic [15:0] m_note = '0;
    logic [11:0] m_dur = '0;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advances the model across one clock edge using the bus values the bench is driving.
    task automatic model_edge();
        int          e;
        logic        wr;
        logic        flush;
        logic        note;
        logic        full;
        logic [27:0] h;
        e     = cyc;
        wr    = en && wr_en;
        flush = wr && addr && data_in[15];
        note  = wr && !addr;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_ovf       = 1'b0;
            m_dur       = '0;
            m_idle_from = e;
            m_d         = 0;
            m_t         = 0;
            m_end       = 0;
            return;
        end
        full = (mq.size() == DEPTH);
        if (!flush && (e - 1) >= m_idle_from && mq.size() > 0) begin
            h      = mq.pop_front();
            m_t    = e;
            m_note = h[27:12];
            m_d    = int'(h[11:0]);
            exp_q.push_back('{e + 1, m_note});
            if (m_d == 0) begin
                m_idle_from = e + 1;
            end else begin
                m_end = e + m_d * TD;
`ifdef NOTE_SEQ_AUTO_MUTE_EN
                exp_q.push_back('{m_end + 2, {m_note[15:14], 14'b0}});
                m_idle_from = m_end + 2;
`else
                m_idle_from = m_end + 1;
`endif
            end
        end
        if (flush) begin
            mq.delete();
            if (m_d != 0 && (e - 1) >= m_t && (e - 1) <= m_end) begin
`ifdef NOTE_SEQ_AUTO_MUTE_EN
                while (exp_q.size() > 0 && exp_q[$].cyc > e) begin
                    void'(exp_q.pop_back());
                end
                exp_q.push_back('{e + 1, {m_note[15:14], 14'b0}});
                m_idle_from = e + 1;
`else
                m_idle_from = e;
`endif
            end
        end
        if (note) begin
            if (full) m_ovf = 1'b1;
            else mq.push_back({data_in, m_dur});
        end
        if (wr && addr) begin
            m_dur = data_in[11:0];
            if (data_in[14]) m_ovf = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        logic       exp_p;
        logic [3:0] exp_st;
        exp_p  = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        exp_st = {cyc < m_idle_from, mq.size() == DEPTH, mq.size() == 0, m_ovf};
        check("status", status, exp_st);
        check("snd_wr_en", snd_wr_en, exp_p);
        if (exp_p) begin
            check("snd_data", snd_data, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (snd_wr_en === 1'b1) log_q.push_back('{cyc, snd_data});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_bus();
        en      = 1'b0;
        wr_en   = 1'b0;
        addr    = 1'b0;
        data_in = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus(input logic e, input logic a, input logic [15:0] d);
        en      = e;
        wr_en   = 1'b1;
        addr    = a;
        data_in = d;
        tick();
        idle_bus();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int r;
        idle_bus();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_status", status, 4'b0010);
        check("rst_wr", snd_wr_en, 1'b0);
        check("rst_data", snd_data, 16'h0000);

        // single note, d=3
        bus(1, 1, 16'h0003);
        log_q.delete();
        bus(1, 0, 16'h4123);
        w = cyc;
        run(3);
        check("single_cnt", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("single_lat", log_q[0].cyc - w, 2);
            check("single_data", log_q[0].data, 16'h4123);
        end
        run(15);
`ifdef NOTE_SEQ_AUTO_MUTE_EN
        check("mute_cnt", log_q.size(), 2);
        if (log_q.size() > 1) begin
            check("mute_gap", log_q[1].cyc - log_q[0].cyc, 13);
            check("mute_data", log_q[1].data, 16'h4000);
        end
`else
        check("nomute_cnt", log_q.size(), 1);
`endif

        // chord, d=0
        bus(1, 1, 16'h0000);
        log_q.delete();
        bus(1, 0, 16'h0100);
        bus(1, 0, 16'h4200);
        bus(1, 0, 16'h8300);
        run(8);
        check("chord_cnt", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("chord_d0", log_q[0].data, 16'h0100);
            check("chord_d1", log_q[1].data, 16'h4200);
            check("chord_d2", log_q[2].data, 16'h8300);
            check("chord_gap0", log_q[1].cyc - log_q[0].cyc, 2);
            check("chord_gap1", log_q[2].cyc - log_q[1].cyc, 2);
        end
        check("chord_idle", status, 4'b0010);

        // overflow: d=50 keeps the FSM in WAIT
        bus(1, 1, 16'h0032);
        log_q.delete();
        for (int i = 0; i < 6; i++) bus(1, 0, 16'h1000 + 16'(i));
        check("ovf_status", status, 4'b1101);
        bus(1, 1, 16'h4000);
        check("ovf_clear", status, 4'b1100);
        run(1100);
`ifdef NOTE_SEQ_AUTO_MUTE_EN
        check("ovf_played", log_q.size(), 10);
`else
        check("ovf_played", log_q.size(), 5);
        if (log_q.size() == 5) check("ovf_last", log_q[4].data, 16'h1004);
`endif
        check("ovf_done", status, 4'b0010);

        // flush mid-note
        bus(1, 1, 16'h0064);
        bus(1, 0, 16'h8555);
        bus(1, 0, 16'hC111);
        run(20);
        log_q.delete();
        bus(1, 1, 16'h8000);
`ifdef NOTE_SEQ_AUTO_MUTE_EN
        check("flush_1", status, 4'b1010);
`else
        check("flush_1", status, 4'b0010);
`endif
        tick();
        check("flush_2", status, 4'b0010);
        run(10);
`ifdef NOTE_SEQ_AUTO_MUTE_EN
        check("flush_pulses", log_q.size(), 1);
        if (log_q.size() > 0) check("flush_mute", log_q[0].data, 16'h8000);
`else
        check("flush_pulses", log_q.size(), 0);
`endif

        // reset mid-WAIT
        bus(1, 1, 16'h0064);
        bus(1, 0, 16'h4777);
        bus(1, 0, 16'h0888);
        run(30);
        do_reset();
        check("rstw_wr", snd_wr_en, 1'b0);
        check("rstw_data", snd_data, 16'h0000);
        check("rstw_status", status, 4'b0010);
        log_q.delete();
        run(450);
        check("rstw_quiet", log_q.size(), 0);

        // gating: en=0 ignores both note and control writes
        log_q.delete();
        bus(0, 0, 16'h1234);
        bus(0, 1, 16'h0005);
        run(4);
        check("gate_status", status, 4'b0010);
        check("gate_quiet", log_q.size(), 0);
        bus(1, 0, 16'h1111);
        run(4);
        check("gate_dur0", status, 4'b0010);
        check("gate_one", log_q.size(), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
            end else if (r < 30) begin
                en      = ($urandom_range(0, 9) != 0);
                wr_en   = 1'b1;
                addr    = 1'b0;
                data_in = 16'($urandom_range(0, 65535));
            end else if (r < 38) begin
                en      = ($urandom_range(0, 9) != 0);
                wr_en   = 1'b1;
                addr    = 1'b1;
                data_in = {($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                           2'b00, 12'($urandom_range(0, 3))};
            end else begin
                wr_en = ($urandom_range(0, 9) == 0);
                en    = 1'b0;
            end
            tick();
            idle_bus();
            rst = 1'b0;
        end
        run(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
